// File: rtl/muller_pkg.sv
// Shared types and the C-element rule for the clocked Muller micropipeline.
package muller_pkg;

  localparam logic C_RST_VAL = 1'b0;

  // One stage's C-element state; the pipe's stage vector is stage_t [DEPTH-1:0].
  typedef logic stage_t;

  function automatic logic c_next(input logic a, input logic b, input logic o);
    return (a == b) ? a : o;
  endfunction

endpackage

// File: rtl/mullerc_sync.sv
// One clocked Muller C-element: follows its inputs when they agree, otherwise holds.
module mullerc_sync
  import muller_pkg::*;
#(
  parameter logic Rval = C_RST_VAL
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic o
);

  logic o_d;
  logic o_q;

  always_comb begin
    o_d = c_next(a, b, o_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= Rval;
    end else begin
      o_q <= o_d;
    end
  end

  assign o = o_q;

endmodule

// File: rtl/muller_pipe.sv
// DEPTH-stage, WIDTH-bit four-phase bundled-data micropipeline built from clocked C-elements.
// Define MULLER_PIPE_PROTOCOL_CHECK_EN to build the sticky handshake-violation checker.
module muller_pipe
  import muller_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             proto_err
);

  stage_t [DEPTH-1:0] c;
  logic   [DEPTH-1:0] a_vec;
  logic   [DEPTH-1:0] b_vec;
  logic   [DEPTH-1:0] cap;
  logic   [WIDTH-1:0] src    [DEPTH];
  logic   [WIDTH-1:0] data_d [DEPTH];
  logic   [WIDTH-1:0] data_q [DEPTH];

  // The consumer's ack behaves as the state of a virtual stage beyond the last one.
  assign a_vec = {c[DEPTH-2:0], in_req};
  assign b_vec = ~{out_ack, c[DEPTH-1:1]};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    mullerc_sync #(
      .Rval(C_RST_VAL)
    ) u_c (
      .clk(clk),
      .rst(rst),
      .a  (a_vec[i]),
      .b  (b_vec[i]),
      .o  (c[i])
    );

    assign cap[i] = c_next(a_vec[i], b_vec[i], c[i]) & ~c[i];

    if (i == 0) begin : g_first
      assign src[i] = in_data;
    end else begin : g_rest
      assign src[i] = data_q[i-1];
    end
  end

  // Data moves only on a stage's rising request; falling edges leave it in place.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = cap[i] ? src[i] : data_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      data_q <= data_d;
    end
  end

  assign in_ack   = c[0];
  assign out_req  = c[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

`ifdef MULLER_PIPE_PROTOCOL_CHECK_EN
  logic             in_req_d;
  logic             in_req_q;
  logic             out_ack_d;
  logic             out_ack_q;
  logic [WIDTH-1:0] in_data_d;
  logic [WIDTH-1:0] in_data_q;
  logic             proto_err_d;
  logic             proto_err_q;

  // Edges are seen against last cycle's sampled inputs, so the flag lands one cycle late.
  always_comb begin
    in_req_d    = in_req;
    out_ack_d   = out_ack;
    in_data_d   = in_data;
    proto_err_d = proto_err_q;
    if (in_req_q && !in_req && !in_ack) proto_err_d = 1'b1;
    if (!in_req_q && in_req && in_ack) proto_err_d = 1'b1;
    if (in_req_q && in_req && !in_ack && (in_data != in_data_q)) proto_err_d = 1'b1;
    if (!out_ack_q && out_ack && !out_req) proto_err_d = 1'b1;
    if (out_ack_q && !out_ack && out_req) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_req_q    <= 1'b0;
      out_ack_q   <= 1'b0;
      in_data_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      in_req_q    <= in_req_d;
      out_ack_q   <= out_ack_d;
      in_data_q   <= in_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_muller_pipe.sv
// Self-checking bench for muller_pipe: directed handshakes plus randomized streaming
// checked against an in-order token list, fixed latencies and a DEPTH/2 capacity.
module tb_muller_pipe;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int CAP    = DEPTH / 2;
  localparam int BUDGET = 50;
  localparam int NSTR   = 40;

`ifdef MULLER_PIPE_PROTOCOL_CHECK_EN
  localparam logic CHECKER_ON = 1'b1;
`else
  localparam logic CHECKER_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_req;
  logic             in_ack;
  logic [WIDTH-1:0] in_data;
  logic             out_req;
  logic             out_ack;
  logic [WIDTH-1:0] out_data;
  logic             proto_err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] tok  [NSTR];
  int               pgap [NSTR];
  int               cgap [NSTR];
  logic [WIDTH-1:0] bp_exp [3];

  muller_pipe #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .in_data  (in_data),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data),
    .proto_err(proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitAck(input logic val, input string tag);
    int n = 0;
    while (in_ack !== val && n < BUDGET) begin
      tick();
      n++;
    end
    checkBit(tag, in_ack, val);
  endtask

  task automatic waitReq(input logic val, input string tag);
    int n = 0;
    while (out_req !== val && n < BUDGET) begin
      tick();
      n++;
    end
    checkBit(tag, out_req, val);
  endtask

  // Producer: one full four-phase handshake after an optional idle gap.
  task automatic applyStimulus(input logic [WIDTH-1:0] data, input int gap);
    waitAck(1'b0, "prod_idle");
    repeat (gap) tick();
    in_data = data;
    in_req  = 1'b1;
    waitAck(1'b1, "prod_ack");
    in_req = 1'b0;
    waitAck(1'b0, "prod_rtz");
  endtask

  // Consumer: one full four-phase handshake, acknowledging after an optional delay.
  task automatic recvToken(output logic [WIDTH-1:0] data, input int gap);
    waitReq(1'b1, "cons_req");
    repeat (gap) tick();
    data    = out_data;
    out_ack = 1'b1;
    waitReq(1'b0, "cons_rtz");
    out_ack = 1'b0;
  endtask

  // Empty pipe: ack after 1 cycle, out_req after DEPTH, RTZ wave also DEPTH cycles.
  task automatic singleToken(input logic [WIDTH-1:0] data, input string p);
    in_data = data;
    in_req  = 1'b1;
    out_ack = 1'b0;
    tick();
    checkBit({p, "_in_ack_lat1"}, in_ack, 1'b1);
    checkBit({p, "_out_req_idle"}, out_req, 1'b0);
    repeat (DEPTH - 2) tick();
    checkBit({p, "_out_req_early"}, out_req, 1'b0);
    tick();
    checkBit({p, "_out_req_latD"}, out_req, 1'b1);
    checkOutput({p, "_out_data"}, out_data, data);
    checkBit({p, "_in_ack_held"}, in_ack, 1'b1);
    in_req  = 1'b0;
    out_ack = 1'b1;
    tick();
    checkBit({p, "_in_ack_rtz"}, in_ack, 1'b0);
    repeat (DEPTH - 2) tick();
    checkBit({p, "_out_req_hold"}, out_req, 1'b1);
    tick();
    checkBit({p, "_out_req_rtz"}, out_req, 1'b0);
    out_ack = 1'b0;
    repeat (2 * DEPTH) tick();
    checkBit({p, "_no_second_token"}, out_req, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] d;

    rst     = 1'b0;
    in_req  = 1'b0;
    out_ack = 1'b0;
    in_data = '0;

    // Reset asserted before any clock edge clears every output at once.
    #2 rst = 1'b1;
    #1;
    checkBit("rst_in_ack", in_ack, 1'b0);
    checkBit("rst_out_req", out_req, 1'b0);
    checkOutput("rst_out_data", out_data, '0);
    checkBit("rst_proto_err", proto_err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_req  = 1'($urandom_range(0, 1));
      out_ack = 1'($urandom_range(0, 1));
      in_data = WIDTH'($urandom);
      tick();
    end
    checkBit("rst_hold_in_ack", in_ack, 1'b0);
    checkBit("rst_hold_out_req", out_req, 1'b0);
    checkOutput("rst_hold_out_data", out_data, '0);
    in_req  = 1'b0;
    out_ack = 1'b0;
    in_data = '0;
    rst     = 1'b0;
    tick();

    $display("[TB] single token");
    singleToken(8'hA5, "single");

    $display("[TB] backpressure");
    bp_exp[0] = 8'h11;
    bp_exp[1] = 8'h22;
    bp_exp[2] = 8'h33;
    for (int k = 0; k < CAP; k++) applyStimulus(bp_exp[k], 0);
    in_data = bp_exp[2];
    in_req  = 1'b1;
    repeat (4 * DEPTH) tick();
    checkBit("bp_third_unacked", in_ack, 1'b0);
    checkBit("bp_full_out_req", out_req, 1'b1);
    checkOutput("bp_head_data", out_data, bp_exp[0]);
    fork
      begin
        waitAck(1'b1, "bp_third_ack");
        in_req = 1'b0;
        waitAck(1'b0, "bp_third_rtz");
      end
      begin
        for (int k = 0; k < 3; k++) begin
          logic [WIDTH-1:0] r;
          recvToken(r, 0);
          checkOutput($sformatf("bp_rx%0d", k), r, bp_exp[k]);
        end
      end
    join
    repeat (2 * DEPTH) tick();
    checkBit("bp_drained", out_req, 1'b0);

    $display("[TB] streaming");
    for (int k = 0; k < NSTR; k++) begin
      if (k < 16) begin
        tok[k]  = WIDTH'(k);
        pgap[k] = 0;
        cgap[k] = 0;
      end else begin
        tok[k]  = WIDTH'($urandom);
        pgap[k] = $urandom_range(0, 3);
        cgap[k] = $urandom_range(0, 3);
      end
    end
    fork
      begin
        for (int k = 0; k < NSTR; k++) applyStimulus(tok[k], pgap[k]);
      end
      begin
        for (int k = 0; k < NSTR; k++) begin
          logic [WIDTH-1:0] r;
          recvToken(r, cgap[k]);
          checkOutput($sformatf("stream_rx%0d", k), r, tok[k]);
        end
      end
    join
    repeat (2 * DEPTH) tick();
    checkBit("stream_no_extra", out_req, 1'b0);
    checkBit("stream_proto_err", proto_err, 1'b0);

    $display("[TB] reset mid-operation");
    applyStimulus(8'hC1, 0);
    applyStimulus(8'hC2, 0);
    repeat (DEPTH) tick();
    checkBit("midrst_pre_out_req", out_req, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("midrst_in_ack", in_ack, 1'b0);
    checkBit("midrst_out_req", out_req, 1'b0);
    checkOutput("midrst_out_data", out_data, '0);
    checkBit("midrst_proto_err", proto_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    singleToken(8'h5A, "postrst");

    $display("[TB] protocol checker");
    for (int k = 0; k < CAP; k++) applyStimulus(WIDTH'(8'h60 + k), 0);
    in_data = 8'h77;
    in_req  = 1'b1;
    repeat (3) tick();
    checkBit("chk_pre_err", proto_err, 1'b0);
    in_req = 1'b0;
    tick();
    checkBit("chk_err_set", proto_err, CHECKER_ON);
    repeat (3) tick();
    checkBit("chk_err_sticky", proto_err, CHECKER_ON);
    rst = 1'b1;
    #1;
    checkBit("chk_err_rst", proto_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
